lfsr_bist_gen: RTL

- Parametrised Fibonacci LFSR engine for the BIST path: width, feedback polynomial and reset seed are parameters.
- Runs as a test-pattern generator (TPG) or as a multiple-input signature register (MISR).
- Run length is programmable. Seeds are loadable at run time. All-zero lock-up is detected and recovered automatically.
- Sits between the BIST controller (start/seed/count) and the CUT: drives patterns in TPG mode, compacts CUT responses in MISR mode.

---
 rtl/lfsr_bist_gen_pkg.sv | 19 +
 rtl/lfsr_bist_gen_if.sv | 27 ++
 rtl/lfsr_bist_gen_core.sv | 41 ++++
 rtl/lfsr_bist_gen.sv | 103 ++++++++++
 4 files changed

// File: rtl/lfsr_bist_gen_pkg.sv
// Shared types and constants for the BIST LFSR engine: FSM state encoding,
// mode values and known-good maximal feedback masks.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_TPG  = 1'b0;
  localparam logic MODE_MISR = 1'b1;

  // Maximal-length Fibonacci tap masks, bit i set => q[i] feeds the XOR
  localparam logic [2:0]  POLY_W3  = 3'b110;
  localparam logic [7:0]  POLY_W8  = 8'hB8;
  localparam logic [15:0] POLY_W16 = 16'hB400;

endpackage

// File: rtl/lfsr_bist_gen_if.sv
// Controller/CUT-facing bundle of the LFSR engine; master = BIST controller side,
// slave = the engine itself.
interface lfsr_bist_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             mode;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic [CNT_W-1:0] n_patterns;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             lockup;

  modport master (
    output start, mode, seed_load, seed_in, n_patterns, din,
    input  q, busy, done, lockup
  );

  modport slave (
    input  start, mode, seed_load, seed_in, n_patterns, din,
    output q, busy, done, lockup
  );
endinterface

// File: rtl/lfsr_bist_gen_core.sv
// Fibonacci LFSR register with TPG/MISR step and all-zero recovery in TPG mode.
// Load beats step; reset beats both.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] POLY     = POLY_W8,
  parameter logic [WIDTH-1:0] SEED_RST = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_step,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_misr_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_q,
  output logic             o_zero_fix
);

  logic [WIDTH-1:0] r_q;
  logic             w_fb;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_next;

  assign w_fb       = ^(r_q & POLY);
  assign w_shifted  = {r_q[WIDTH-2:0], w_fb};
  assign w_next     = i_misr_en ? (w_shifted ^ i_din) : w_shifted;
  // A zero signature is legal when compacting, so only TPG steps recover
  assign o_zero_fix = i_step && !i_misr_en && (r_q == '0);

  always_ff @(posedge clk) begin
    if (rst)             r_q <= SEED_RST;
    else if (i_load)     r_q <= i_load_val;
    else if (o_zero_fix) r_q <= SEED_RST;
    else if (i_step)     r_q <= w_next;
  end

  assign o_q = r_q;

endmodule

// File: rtl/lfsr_bist_gen.sv
// BIST pattern generator / signature register: run-control FSM, step counter
// and sticky lock-up flag wrapped around lfsr_core.
module lfsr_bist_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] POLY     = POLY_W8,
  parameter logic [WIDTH-1:0] SEED_RST = '1,
  parameter int               CNT_W    = 16
) (
  input logic           CLK,
  input logic           RST,
  lfsr_bist_gen_if.slave bus
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_n;
  logic             r_mode;
  logic             r_busy;
  logic             r_done;
  logic             r_lockup;
  logic             w_step;
  logic             w_zero_fix;
  logic [WIDTH-1:0] w_q;

  // seed_load aborts a run on the same edge, so it must also suppress the step
  assign w_step = (r_state == ST_RUN) && !bus.seed_load;

  lfsr_core #(
    .WIDTH    (WIDTH),
    .POLY     (POLY),
    .SEED_RST (SEED_RST)
  ) u_core (
    .clk        (CLK),
    .rst        (RST),
    .i_step     (w_step),
    .i_load     (bus.seed_load),
    .i_load_val (bus.seed_in),
    .i_misr_en  (r_mode),
    .i_din      (bus.din),
    .o_q        (w_q),
    .o_zero_fix (w_zero_fix)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_n      <= '0;
      r_mode   <= MODE_TPG;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_lockup <= 1'b0;
    end else if (bus.seed_load) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_mode <= bus.mode;
            r_n    <= bus.n_patterns;
            r_cnt  <= '0;
            if (bus.n_patterns == '0) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_zero_fix) r_lockup <= 1'b1;
          // r_n is nonzero here, so n-1 never underflows
          if (r_cnt == r_n - CNT_W'(1)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q      = w_q;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.lockup = r_lockup;

endmodule
